// File: rtl/snn_core_param_if.sv
// Handshake and memory bus of snn_core_param: control/result signals plus the
// image RAM, weight ROM and activation LUT ports.
`timescale 1ns/1ps
interface snn_core_param_if #(
   parameter int N_IN  = 784,
   parameter int N_HID = 32,
   parameter int N_OUT = 10
);
   localparam int IAW = $clog2(N_IN);
   localparam int HAW = (N_HID > 1) ? $clog2(N_HID) : 1;
   localparam int OAW = $clog2(N_OUT);

   logic                   start;
   logic                   abort;
   logic                   busy;
   logic                   done;
   logic [OAW-1:0]         digit;
   logic [OAW-1:0]         digit2;
   logic [7:0]             margin;
   logic [IAW-1:0]         addr_input_unit;
   logic                   q_input;
   logic [HAW+IAW-1:0]     addr_w_h;
   logic signed [7:0]      w_h;
   logic [OAW+HAW-1:0]     addr_w_o;
   logic signed [7:0]      w_o;
   logic [10:0]            act_addr;
   logic signed [7:0]      act_q;

   modport slave (
      input  start, abort, q_input, w_h, w_o, act_q,
      output busy, done, digit, digit2, margin,
             addr_input_unit, addr_w_h, addr_w_o, act_addr
   );

   modport master (
      output start, abort, q_input, w_h, w_o, act_q,
      input  busy, done, digit, digit2, margin,
             addr_input_unit, addr_w_h, addr_w_o, act_addr
   );
endinterface

// File: rtl/snn_core_param.sv
// Parametrised input-hidden-output inference core over external ROMs and an
// activation LUT; reports best class, runner-up and their activation margin.
`timescale 1ns/1ps
module snn_core_param #(
   parameter int N_IN  = 784,
   parameter int N_HID = 32,
   parameter int N_OUT = 10,
   parameter int ACC_W = 26
)(
   input logic clk,
   input logic rst_n,
   snn_core_param_if.slave bus
);
   localparam int IAW = $clog2(N_IN);
   localparam int HAW = (N_HID > 1) ? $clog2(N_HID) : 1;
   localparam int OAW = $clog2(N_OUT);
   localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'(1023);
   localparam logic signed [ACC_W-1:0] S_MIN = ACC_W'(-1024);

   typedef enum logic [3:0] {
      IDLE, HID_MAC, HID_DRAIN, HID_ACT, HID_WR,
      OUT_MAC, OUT_DRAIN, OUT_ACT, OUT_CMP, DONE
   } state_t;

   state_t                  state;
   logic [IAW-1:0]          i_cnt;
   logic [HAW-1:0]          h_cnt, j_cnt;
   logic [OAW-1:0]          o_cnt;
   logic signed [ACC_W-1:0] acc, acc_sum, scaled;
   logic signed [7:0]       op_a, op_b, hid_q;
   logic signed [15:0]      prod;
   logic                    mac_en, out_phase;
   logic [10:0]             act_next, act_addr;
   logic signed [7:0]       hidden [N_HID];
   logic signed [7:0]       best, second, nb, ns;
   logic [OAW-1:0]          best_idx, second_idx, nbi, nsi;
   logic                    busy, done;
   logic [OAW-1:0]          digit, digit2;
   logic [7:0]              margin;
   logic                    i_last, h_last, j_last, o_last;

   assign i_last = (i_cnt == IAW'(N_IN - 1));
   assign h_last = (h_cnt == HAW'(N_HID - 1));
   assign j_last = (j_cnt == HAW'(N_HID - 1));
   assign o_last = (o_cnt == OAW'(N_OUT - 1));

   // Operands arrive one cycle after their address, so the layer select and
   // accumulate enable are delayed copies of the MAC state.
   always_comb begin
      op_a    = out_phase ? hid_q : (bus.q_input ? 8'sh7F : 8'sh00);
      op_b    = out_phase ? bus.w_o : bus.w_h;
      prod    = op_a * op_b;
      acc_sum = acc + ACC_W'(prod);
      scaled  = acc_sum >>> 7;
      if (scaled > S_MAX)
         act_next = 11'h7FF;
      else if (scaled < S_MIN)
         act_next = 11'h000;
      else
         act_next = scaled[10:0] ^ 11'h400;
   end

   always_comb begin
      nb  = best;
      ns  = second;
      nbi = best_idx;
      nsi = second_idx;
      if (bus.act_q > best) begin
         nb  = bus.act_q;
         nbi = o_cnt;
         ns  = best;
         nsi = best_idx;
      end else if (bus.act_q > second) begin
         ns  = bus.act_q;
         nsi = o_cnt;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mac_en    <= 1'b0;
         out_phase <= 1'b0;
         hid_q     <= '0;
      end else begin
         mac_en    <= !bus.abort && (state == HID_MAC || state == OUT_MAC);
         out_phase <= (state == OUT_MAC);
         hid_q     <= hidden[j_cnt];
      end
   end

   always_ff @(posedge clk) begin
      if (state == HID_WR)
         hidden[h_cnt] <= bus.act_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         i_cnt      <= '0;
         h_cnt      <= '0;
         j_cnt      <= '0;
         o_cnt      <= '0;
         acc        <= '0;
         act_addr   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         digit      <= '0;
         digit2     <= '0;
         margin     <= '0;
         best       <= 8'sh80;
         second     <= 8'sh80;
         best_idx   <= '0;
         second_idx <= '0;
      end else if (bus.abort && state != IDLE) begin
         state  <= IDLE;
         i_cnt  <= '0;
         h_cnt  <= '0;
         j_cnt  <= '0;
         o_cnt  <= '0;
         acc    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         digit  <= '0;
         digit2 <= '0;
         margin <= '0;
      end else begin
         if (mac_en)
            acc <= acc_sum;
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  state      <= HID_MAC;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  i_cnt      <= '0;
                  h_cnt      <= '0;
                  j_cnt      <= '0;
                  o_cnt      <= '0;
                  acc        <= '0;
                  best       <= 8'sh80;
                  second     <= 8'sh80;
                  best_idx   <= '0;
                  second_idx <= '0;
               end
            end
            HID_MAC: begin
               i_cnt <= i_last ? '0 : i_cnt + IAW'(1);
               if (i_last)
                  state <= HID_DRAIN;
            end
            HID_DRAIN: begin
               act_addr <= act_next;
               state    <= HID_ACT;
            end
            HID_ACT: state <= HID_WR;
            HID_WR: begin
               acc   <= '0;
               h_cnt <= h_last ? '0 : h_cnt + HAW'(1);
               state <= h_last ? OUT_MAC : HID_MAC;
            end
            OUT_MAC: begin
               j_cnt <= j_last ? '0 : j_cnt + HAW'(1);
               if (j_last)
                  state <= OUT_DRAIN;
            end
            OUT_DRAIN: begin
               act_addr <= act_next;
               state    <= OUT_ACT;
            end
            OUT_ACT: state <= OUT_CMP;
            OUT_CMP: begin
               acc        <= '0;
               best       <= nb;
               second     <= ns;
               best_idx   <= nbi;
               second_idx <= nsi;
               if (o_last) begin
                  o_cnt  <= '0;
                  state  <= DONE;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  digit  <= nbi;
                  digit2 <= nsi;
                  margin <= nb - ns;
               end else begin
                  o_cnt <= o_cnt + OAW'(1);
                  state <= OUT_MAC;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.addr_input_unit = i_cnt;
   assign bus.addr_w_h        = {h_cnt, i_cnt};
   assign bus.addr_w_o        = {o_cnt, j_cnt};
   assign bus.act_addr        = act_addr;
   assign bus.busy            = busy;
   assign bus.done            = done;
   assign bus.digit           = digit;
   assign bus.digit2          = digit2;
   assign bus.margin          = margin;
endmodule

// File: tb/tb_snn_core_param.sv
// Scoreboard bench for snn_core_param: default-size and small-size instances
// driven from behavioural ROM/LUT models, results checked against a reference model.
`timescale 1ns/1ps
module tb_snn_core_param;
   localparam int N_IN = 784, N_HID = 32, N_OUT = 10;
   localparam int IAW = $clog2(N_IN), HAW = $clog2(N_HID), OAW = $clog2(N_OUT);
   localparam int S_IN = 16, S_HID = 4, S_OUT = 3;
   localparam int S_IAW = 4, S_HAW = 2, S_OAW = 2;

   typedef struct {
      int lat;
      int dig;
      int dig2;
      int marg;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic signed [7:0] hid_w = 8'sh01;
   int omode = 0;
   int pmode = 0;
   int n_checks = 0;
   int n_fail = 0;
   exp_t sb_q[$];
   exp_t s_q[$];
   exp_t got;
   int cnt, mi, mh, mo, mj;
   bit done_seen;

   always #5 clk = ~clk;

   snn_core_param_if #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT)) bus ();
   snn_core_param_if #(.N_IN(S_IN), .N_HID(S_HID), .N_OUT(S_OUT)) sbus ();

   snn_core_param #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .ACC_W(26)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus));
   snn_core_param #(.N_IN(S_IN), .N_HID(S_HID), .N_OUT(S_OUT), .ACC_W(26)) sdut (
      .clk(clk), .rst_n(rst_n), .bus(sbus));

   function automatic logic pix(input int a, input int pm);
      return (pm == 0) ? 1'b1 : ((a % 3) != 0);
   endfunction

   function automatic logic signed [7:0] ow(input int o, input int om);
      if (om == 0) return (o == 3) ? 8'sd3 : (o == 8) ? 8'sd2 : 8'sd1;
      if (om == 2) return (o == 1) ? 8'sd5 : (o == 2) ? 8'sd3 : 8'sd1;
      return 8'sd1;
   endfunction

   function automatic logic signed [7:0] lut(input logic [10:0] a);
      int s;
      s = int'(a) - 1024;
      if (s > 127) s = 127;
      if (s < -128) s = -128;
      return 8'(s);
   endfunction

   function automatic int act(input longint acc);
      longint s;
      s = acc >>> 7;
      if (s > 1023) s = 1023;
      if (s < -1024) s = -1024;
      return int'(lut(11'(s + 1024)));
   endfunction

   function automatic exp_t model(input int n_in, input int n_hid, input int n_out,
                                  input logic signed [7:0] hw, input int om, input int pm);
      exp_t e;
      longint acc;
      int hid [64];
      int v, best, second, bi, si;
      best = -128; second = -128; bi = 0; si = 0;
      for (int h = 0; h < n_hid; h++) begin
         acc = 0;
         for (int i = 0; i < n_in; i++)
            if (pix(i, pm)) acc += 127 * int'(hw);
         hid[h] = act(acc);
      end
      for (int o = 0; o < n_out; o++) begin
         acc = 0;
         for (int j = 0; j < n_hid; j++)
            acc += hid[j] * int'(ow(o, om));
         v = act(acc);
         if (v > best) begin
            second = best; si = bi; best = v; bi = o;
         end else if (v > second) begin
            second = v; si = o;
         end
      end
      e.lat  = n_hid * (n_in + 3) + n_out * (n_hid + 3) + 1;
      e.dig  = bi;
      e.dig2 = si;
      e.marg = best - second;
      return e;
   endfunction

   // Synchronous memories with one-cycle read latency
   always @(posedge clk) begin
      bus.q_input  <= pix(int'(bus.addr_input_unit), pmode);
      bus.w_h      <= hid_w;
      bus.w_o      <= ow(int'(bus.addr_w_o[OAW+HAW-1:HAW]), omode);
      bus.act_q    <= lut(bus.act_addr);
      sbus.q_input <= pix(int'(sbus.addr_input_unit), pmode);
      sbus.w_h     <= hid_w;
      sbus.w_o     <= ow(int'(sbus.addr_w_o[S_OAW+S_HAW-1:S_HAW]), omode);
      sbus.act_q   <= lut(sbus.act_addr);
   end

   task automatic checkOutput(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic signed [7:0] hw_v, input int om, input int pm,
                                input int hold, input int act_exp, input string tag);
      exp_t e;
      int c, limit, xi, xh, xo, xj;
      bit busy_low;
      hid_w = hw_v; omode = om; pmode = pm;
      e = model(N_IN, N_HID, N_OUT, hw_v, om, pm);
      sb_q.push_back(e);
      limit = e.lat + 20;
      bus.start = 1'b1;
      @(negedge clk);
      checkOutput({tag, "_busy_rise"}, bus.busy, 1);
      c = 1; busy_low = 0; xi = 0; xh = 0; xo = 0; xj = 0;
      while (!bus.done && c <= limit) begin
         if (c >= hold) bus.start = 1'b0;
         if (!bus.busy) busy_low = 1;
         if (int'(bus.addr_input_unit) > xi) xi = int'(bus.addr_input_unit);
         if (int'(bus.addr_w_h[HAW+IAW-1:IAW]) > xh) xh = int'(bus.addr_w_h[HAW+IAW-1:IAW]);
         if (int'(bus.addr_w_o[OAW+HAW-1:HAW]) > xo) xo = int'(bus.addr_w_o[OAW+HAW-1:HAW]);
         if (int'(bus.addr_w_o[HAW-1:0]) > xj) xj = int'(bus.addr_w_o[HAW-1:0]);
         if (act_exp >= 0 && c < N_HID * (N_IN + 3) && ((c - 1) % (N_IN + 3)) == N_IN + 1)
            checkOutput({tag, "_hid_act_addr"}, bus.act_addr, act_exp);
         @(negedge clk);
         c++;
      end
      bus.start = 1'b0;
      e = sb_q.pop_front();
      checkOutput({tag, "_latency"}, c, e.lat);
      checkOutput({tag, "_digit"}, bus.digit, e.dig);
      checkOutput({tag, "_digit2"}, bus.digit2, e.dig2);
      checkOutput({tag, "_margin"}, bus.margin, e.marg);
      checkOutput({tag, "_busy_at_done"}, bus.busy, 0);
      checkOutput({tag, "_busy_dropped"}, busy_low, 0);
      checkOutput({tag, "_max_in"}, xi, N_IN - 1);
      checkOutput({tag, "_max_hid"}, xh, N_HID - 1);
      checkOutput({tag, "_max_out"}, xo, N_OUT - 1);
      checkOutput({tag, "_max_j"}, xj, N_HID - 1);
   endtask

   initial begin
      rst_n = 1'b0;
      bus.start = 1'b0; bus.abort = 1'b0;
      sbus.start = 1'b0; sbus.abort = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_busy", bus.busy, 0);
      checkOutput("rst_done", bus.done, 0);
      checkOutput("rst_digit", bus.digit, 0);
      checkOutput("rst_digit2", bus.digit2, 0);
      checkOutput("rst_margin", bus.margin, 0);
      checkOutput("rst_addr_in", bus.addr_input_unit, 0);
      checkOutput("rst_addr_wh", bus.addr_w_h, 0);
      checkOutput("rst_addr_wo", bus.addr_w_o, 0);
      checkOutput("rst_act_addr", bus.act_addr, 0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] small instance 16-4-3");
      hid_w = 8'sh7F; omode = 2; pmode = 0;
      s_q.push_back(model(S_IN, S_HID, S_OUT, hid_w, omode, pmode));
      sbus.start = 1'b1;
      @(negedge clk);
      sbus.start = 1'b0;
      cnt = 1; mi = 0; mh = 0; mo = 0; mj = 0;
      while (!sbus.done && cnt <= 200) begin
         if (int'(sbus.addr_input_unit) > mi) mi = int'(sbus.addr_input_unit);
         if (int'(sbus.addr_w_h[S_HAW+S_IAW-1:S_IAW]) > mh) mh = int'(sbus.addr_w_h[S_HAW+S_IAW-1:S_IAW]);
         if (int'(sbus.addr_w_o[S_OAW+S_HAW-1:S_HAW]) > mo) mo = int'(sbus.addr_w_o[S_OAW+S_HAW-1:S_HAW]);
         if (int'(sbus.addr_w_o[S_HAW-1:0]) > mj) mj = int'(sbus.addr_w_o[S_HAW-1:0]);
         @(negedge clk);
         cnt++;
      end
      got = s_q.pop_front();
      checkOutput("small_latency", cnt, got.lat);
      checkOutput("small_digit", sbus.digit, got.dig);
      checkOutput("small_digit2", sbus.digit2, got.dig2);
      checkOutput("small_margin", sbus.margin, got.marg);
      checkOutput("small_max_in", mi, S_IN - 1);
      checkOutput("small_max_hid", mh, S_HID - 1);
      checkOutput("small_max_out", mo, S_OUT - 1);
      checkOutput("small_max_j", mj, S_HID - 1);

      $display("[TB] ranking pass with start held");
      applyStimulus(8'sh01, 0, 0, 3000, -1, "rank");

      $display("[TB] restart from DONE, negative saturation, abort");
      hid_w = 8'sh80; omode = 0; pmode = 0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      checkOutput("restart_done_low", bus.done, 0);
      checkOutput("restart_busy", bus.busy, 1);
      checkOutput("restart_digit_hold", bus.digit, 3);
      for (cnt = 1; cnt < 1000; cnt++) begin
         if (cnt == N_IN + 2 || cnt == N_IN + 3)
            checkOutput("neg_sat_act_addr", bus.act_addr, 0);
         @(negedge clk);
      end
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      checkOutput("abort_busy", bus.busy, 0);
      checkOutput("abort_done", bus.done, 0);
      checkOutput("abort_digit", bus.digit, 0);
      checkOutput("abort_digit2", bus.digit2, 0);
      checkOutput("abort_margin", bus.margin, 0);
      done_seen = 0;
      repeat (100) begin
         @(negedge clk);
         if (bus.done) done_seen = 1;
      end
      checkOutput("abort_no_done", done_seen, 0);

      $display("[TB] tie pass with positive saturation");
      applyStimulus(8'sh7F, 1, 1, 0, 2047, "tie");

      bus.start = 1'b1;
      bus.abort = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      checkOutput("abort_over_start_busy", bus.busy, 0);
      checkOutput("abort_over_start_done", bus.done, 0);
      checkOutput("abort_over_start_digit2", bus.digit2, 0);

      $display("[TB] ranking pass after abort");
      applyStimulus(8'sh01, 0, 0, 0, -1, "rerun");

      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (200) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("midrst_busy", bus.busy, 0);
      checkOutput("midrst_done", bus.done, 0);
      checkOutput("midrst_digit", bus.digit, 0);
      checkOutput("midrst_digit2", bus.digit2, 0);
      checkOutput("midrst_margin", bus.margin, 0);
      checkOutput("midrst_addr_in", bus.addr_input_unit, 0);
      checkOutput("midrst_addr_wh", bus.addr_w_h, 0);
      checkOutput("midrst_addr_wo", bus.addr_w_o, 0);
      checkOutput("midrst_act_addr", bus.act_addr, 0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/snn_core_param.md
# snn_core_param

Parametrised successor of the fixed 784-32-10 spiking/MLP inference core. Runs one input-to-hidden-to-output forward pass over external synchronous weight ROMs and an external activation LUT, with configurable layer sizes. Reports the winning class, the runner-up class and the confidence margin between them. Sits between the input-image RAM (1 bit per pixel) and the digit display/UART result path, and adds abort and busy handshakes.

## Interface
Parameters:
- N_IN, 784, input units (pixels); ≥2
- N_HID, 32, hidden units; ≥1
- N_OUT, 10, output units; ≥2
- ACC_W, 26, MAC accumulator width (signed); must hold N_IN·128·128
- derived: IAW=$clog2(N_IN), HAW=$clog2(N_HID), OAW=$clog2(N_OUT)

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  system clock; all state updates on its rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin a pass; sampled in IDLE or DONE only
- abort  in  1  cancel a pass in progress
- addr_input_unit  out  IAW  input-image RAM address
- q_input  in  1  pixel bit, valid 1 cycle after its address
- addr_w_h  out  HAW+IAW  hidden weight ROM address {hidden idx, input idx}
- w_h  in  8  signed hidden weight, 1-cycle read latency
- addr_w_o  out  OAW+HAW  output weight ROM address {output idx, hidden idx}
- w_o  in  8  signed output weight, 1-cycle latency
- act_addr  out  11  activation LUT address
- act_q  in  8  signed LUT result, 1-cycle latency
- busy  out  1  pass in progress
- done  out  1  results valid; high for the whole DONE state
- digit  out  OAW  index of the largest output
- digit2  out  OAW  index of the second-largest output
- margin  out  8  unsigned best − second activation

## Operation
- Input operand is q_input ? 8'h7F : 8'h00. All MAC operands are signed 8-bit. The accumulator is signed ACC_W and performs acc += a·b.
- Activation address: s = acc >>> 7, clamped to [−1024, 1023]; act_addr = s + 1024 as 11 bits.
- Hidden activations are stored in an internal N_HID×8 register file. No external hidden RAM is used.
- States and transitions:
  - IDLE: start → HID_MAC. Counters are cleared and acc is cleared.
  - HID_MAC: issue input addresses 0..N_IN−1, one per cycle. After the last address → HID_DRAIN.
  - HID_DRAIN: final product is accumulated → HID_ACT.
  - HID_ACT: act_addr is driven from acc → HID_WR.
  - HID_WR: act_q is written to hidden[h] and acc is cleared. If h = N_HID−1 → OUT_MAC, else h+1 → HID_MAC.
  - OUT_MAC: the output layer follows the same four-state pattern with hidden operands. Its states are OUT_MAC, OUT_DRAIN, OUT_ACT and OUT_CMP, with N_HID issue cycles.
  - OUT_CMP: compare the new activation, then clear acc. If o = N_OUT−1 → DONE, else o+1 → OUT_MAC.
  - DONE: start → HID_MAC (new pass). Otherwise hold.
- Ranking:
  - Entering HID_MAC from IDLE or DONE sets best = second = −128, with both indices 0.
  - At OUT_CMP with value v at index o:
    - if v > best: second ← best and best ← v, with their indices moving the same way;
    - else if v > second: second ← v.
  - Comparisons are strictly greater, so on a tie the lower index wins.
- digit, digit2 and margin are updated when DONE is entered. They hold until the next DONE entry, an abort, or reset.
- abort in any state other than IDLE:
  - next state is IDLE;
  - busy and done go low;
  - digit, digit2 and margin are cleared to 0.
  - abort has priority over start in the same cycle. abort in IDLE is ignored.
- start in a busy state (not IDLE and not DONE) is ignored.

## Timing
- Reset (rst_n low at an edge): state IDLE, all counters 0, acc 0, and every output 0 (addresses, busy, done, digit, digit2, margin).
- start sampled at edge k:
  - busy = 1 from cycle k+1;
  - done rises L cycles after k, with L = N_HID·(N_IN+3) + N_OUT·(N_HID+3) + 1;
  - for the defaults, L = 25535;
  - busy = 0 while done = 1.
- Per hidden unit: N_IN+3 cycles. Per output unit: N_HID+3 cycles.
- The weight address changes every cycle in the MAC states. Address and operand are aligned by a 1-cycle delayed enable. There is no bubble between units beyond the 3 overhead cycles.
- act_addr is stable for the whole ACT state and the WR/CMP state.
- Counter wrap: each counter clears at its terminal count. No address exceeds N−1.

## Test plan
- **Ranking.** Setup: all pixels 1, hidden weights 8'h01 (LUT model is identity clamped to [−128,127]), output rows weight 1 except row 3 = 3 and row 8 = 2. Expected: hidden = 127; outputs 31/63/95; digit=3, digit2=8, margin=32; done exactly 25535 cycles after start.
- **Tie.** All output rows weight 1. Expected: digit=0, digit2=1, margin=0.
- **Saturation.** Hidden weights 8'h7F → act_addr=2047 in every HID_ACT. Hidden weights 8'h80 → act_addr=0.
- **Abort.** Abort at cycle 1000 after start. Expected: busy=0 next cycle, done never rises, digit=0. A following start gives the full-latency, correct result.
- **Start / abort precedence.** start held during a pass → no restart, and latency is unchanged. start in DONE → new pass, done drops next cycle. Reset mid-pass → all outputs 0 next cycle.
- **Non-default parameters.** N_IN=16, N_HID=4, N_OUT=3 with the ranking stimulus. Expected: L=98, with addresses never exceeding 15/3/2.
